// File: rtl/gravsim_pkg.sv
// Shared constants and types for the gravity-sim body record mover.
// Field offsets locate each kinematic word's bank in the register file.
package gravsim_pkg;

    localparam int unsigned OFFSET_POS_X = 23;
    localparam int unsigned OFFSET_POS_Y = 33;
    localparam int unsigned OFFSET_POS_Z = 43;
    localparam int unsigned OFFSET_VEL_X = 53;
    localparam int unsigned OFFSET_VEL_Y = 63;
    localparam int unsigned OFFSET_VEL_Z = 73;

    localparam int unsigned REC_WORDS = 6;
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned REC_W     = REC_WORDS * WORD_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic int unsigned field_base(input logic [2:0] widx);
        case (widx)
            3'd0:    return OFFSET_POS_X;
            3'd1:    return OFFSET_POS_Y;
            3'd2:    return OFFSET_POS_Z;
            3'd3:    return OFFSET_VEL_X;
            3'd4:    return OFFSET_VEL_Y;
            3'd5:    return OFFSET_VEL_Z;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/avl_body_master_if.sv
// Command/response handshake plus Avalon-MM master bus for avl_body_master.
// The master modport is the block's view; slave is the environment's view.
interface avl_body_master_if #(
    parameter int unsigned ADDR_W = 8
);
    logic          CMD_VALID;
    logic          CMD_READY;
    logic          CMD_WRITE;
    logic [3:0]    CMD_BODY;
    logic [191:0]  CMD_WDATA;
    logic          RSP_VALID;
    logic          RSP_READY;
    logic [191:0]  RSP_RDATA;
    logic          RSP_ERR;
    logic [ADDR_W-1:0] AVM_ADDR;
    logic          AVM_READ;
    logic          AVM_WRITE;
    logic [3:0]    AVM_BYTE_EN;
    logic [31:0]   AVM_WRITEDATA;
    logic [31:0]   AVM_READDATA;
    logic          AVM_WAITREQUEST;

    modport master (
        input  CMD_VALID, CMD_WRITE, CMD_BODY, CMD_WDATA, RSP_READY,
        input  AVM_READDATA, AVM_WAITREQUEST,
        output CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERR,
        output AVM_ADDR, AVM_READ, AVM_WRITE, AVM_BYTE_EN, AVM_WRITEDATA
    );

    modport slave (
        output CMD_VALID, CMD_WRITE, CMD_BODY, CMD_WDATA, RSP_READY,
        output AVM_READDATA, AVM_WAITREQUEST,
        input  CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERR,
        input  AVM_ADDR, AVM_READ, AVM_WRITE, AVM_BYTE_EN, AVM_WRITEDATA
    );

endinterface

// File: rtl/body_addr_map.sv
// Maps (record word index, body index) to a register-file word address.
// Purely combinational so other bus masters can share it.
module body_addr_map
    import gravsim_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic [2:0]        widx_i,
    input  logic [3:0]        body_i,
    output logic [ADDR_W-1:0] addr_o
);

    always_comb begin
        addr_o = ADDR_W'(field_base(widx_i) + 32'(body_i));
    end

endmodule

// File: rtl/avl_body_master.sv
// Moves one body's 6-word kinematic record over Avalon-MM, one word per transfer.
// Optional build macro BODY_RANGE_CHECK_EN rejects out-of-range body indices.
module avl_body_master
    import gravsim_pkg::*;
#(
    parameter int unsigned NUM_BODIES = 10,
    parameter int unsigned ADDR_W     = 8
) (
    input  logic CLK,
    input  logic RESET,
    avl_body_master_if.master bus
);

    state_e            state_q, state_d;
    logic [2:0]        widx_q, widx_d;
    logic              wr_q, wr_d;
    logic [3:0]        body_q, body_d;
    logic [REC_W-1:0]  wdata_q, wdata_d;
    logic [REC_W-1:0]  rdata_q, rdata_d;
    logic [ADDR_W-1:0] map_addr;
    logic [WORD_W-1:0] wword;
    logic              in_xfer;

`ifdef BODY_RANGE_CHECK_EN
    logic err_q, err_d;
    logic body_bad;

    assign body_bad = (bus.CMD_BODY == 4'd0) || (32'(bus.CMD_BODY) > NUM_BODIES);
`endif

    body_addr_map #(
        .ADDR_W (ADDR_W)
    ) u_addr_map (
        .widx_i (widx_q),
        .body_i (body_q),
        .addr_o (map_addr)
    );

    assign in_xfer = (state_q == XFER);

    always_comb begin
        wword = '0;
        for (int k = 0; k < REC_WORDS; k++) begin
            if (widx_q == 3'(k)) wword = wdata_q[k*WORD_W +: WORD_W];
        end
    end

    always_comb begin
        state_d = state_q;
        widx_d  = widx_q;
        wr_d    = wr_q;
        body_d  = body_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef BODY_RANGE_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.CMD_VALID) begin
                    wr_d    = bus.CMD_WRITE;
                    body_d  = bus.CMD_BODY;
                    wdata_d = bus.CMD_WDATA;
                    widx_d  = 3'd0;
                    state_d = XFER;
`ifdef BODY_RANGE_CHECK_EN
                    // Bad index: answer immediately, never touch the bus
                    if (body_bad) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                    end
`endif
                end
            end
            XFER: begin
                if (!bus.AVM_WAITREQUEST) begin
                    if (!wr_q) begin
                        for (int k = 0; k < REC_WORDS; k++) begin
                            if (widx_q == 3'(k)) rdata_d[k*WORD_W +: WORD_W] = bus.AVM_READDATA;
                        end
                    end
                    if (widx_q == 3'(REC_WORDS - 1)) begin
                        state_d = RESP;
                    end else begin
                        widx_d = widx_q + 3'd1;
                    end
                end
            end
            RESP: begin
                if (bus.RSP_READY) begin
                    state_d = IDLE;
`ifdef BODY_RANGE_CHECK_EN
                    err_d   = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            widx_q  <= 3'd0;
            wr_q    <= 1'b0;
            body_q  <= 4'd0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef BODY_RANGE_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            widx_q  <= widx_d;
            wr_q    <= wr_d;
            body_q  <= body_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef BODY_RANGE_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    // Bus outputs are gated by state so they read as zero outside a transfer
    always_comb begin
        bus.CMD_READY     = (state_q == IDLE);
        bus.RSP_VALID     = (state_q == RESP);
        bus.RSP_RDATA     = rdata_q;
`ifdef BODY_RANGE_CHECK_EN
        bus.RSP_ERR       = err_q;
`else
        bus.RSP_ERR       = 1'b0;
`endif
        bus.AVM_READ      = in_xfer & ~wr_q;
        bus.AVM_WRITE     = in_xfer & wr_q;
        bus.AVM_ADDR      = in_xfer ? map_addr : '0;
        bus.AVM_WRITEDATA = in_xfer ? wword : '0;
        bus.AVM_BYTE_EN   = 4'b1111;
    end

endmodule

// File: tb/tb_avl_body_master.sv
// Directed bench for avl_body_master with a zero-latency slave returning addr*0x100.
module tb_avl_body_master;

    logic CLK = 1'b0;
    logic RESET;
    logic wait_r;
    int   checks = 0;
    int   fails  = 0;

    always #10 CLK = ~CLK;

    avl_body_master_if #(.ADDR_W(8)) bus ();

    avl_body_master #(
        .NUM_BODIES (10),
        .ADDR_W     (8)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    assign bus.AVM_WAITREQUEST = wait_r;
    assign bus.AVM_READDATA    = {16'h0000, bus.AVM_ADDR, 8'h00};

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [191:0] exp_rd(input int body);
        logic [191:0] r;
        logic [7:0]   a;
        r = '0;
        for (int k = 0; k < 6; k++) begin
            a = 8'(23 + 10 * k + body);
            r[k*32 +: 32] = {16'h0000, a, 8'h00};
        end
        return r;
    endfunction

    task automatic accept_rsp(input string tag);
        bus.RSP_READY = 1'b1;
        @(negedge CLK);
        bus.RSP_READY = 1'b0;
        check({tag, "_ready_again"}, 192'(bus.CMD_READY), 192'(1));
        check({tag, "_rsp_dropped"}, 192'(bus.RSP_VALID), 192'(0));
    endtask

    task automatic run_xfer(input logic wr, input logic [3:0] body, input logic [191:0] wd,
                            input int st0, input int st4, input int exp_lat, input string tag);
        int         word;
        int         cyc;
        int         stall;
        logic [7:0] ea;
        bus.CMD_VALID = 1'b1;
        bus.CMD_WRITE = wr;
        bus.CMD_BODY  = body;
        bus.CMD_WDATA = wd;
        check({tag, "_cmd_ready"}, 192'(bus.CMD_READY), 192'(1));
        @(posedge CLK);
        @(negedge CLK);
        bus.CMD_VALID = 1'b0;
        cyc   = 1;
        word  = 0;
        stall = st0;
        while (word < 6 && cyc < 40) begin
            wait_r = (stall > 0);
            ea = 8'(23 + 10 * word + int'(body));
            #1;
            check({tag, "_addr"}, 192'(bus.AVM_ADDR), 192'(ea));
            check({tag, "_strobe"}, 192'({bus.AVM_READ, bus.AVM_WRITE}), 192'({~wr, wr}));
            check({tag, "_byte_en"}, 192'(bus.AVM_BYTE_EN), 192'(4'hF));
            check({tag, "_busy_rsp"}, 192'(bus.RSP_VALID), 192'(0));
            if (wr) check({tag, "_wdata"}, 192'(bus.AVM_WRITEDATA), 192'(wd[word*32 +: 32]));
            if (stall > 0) begin
                stall--;
            end else begin
                word++;
                if (word == 4) stall = st4;
            end
            @(negedge CLK);
            cyc++;
        end
        wait_r = 1'b0;
        check({tag, "_latency"}, 192'(cyc), 192'(exp_lat));
        check({tag, "_rsp_valid"}, 192'(bus.RSP_VALID), 192'(1));
        check({tag, "_strobe_off"}, 192'({bus.AVM_READ, bus.AVM_WRITE}), 192'(0));
        check({tag, "_rsp_err"}, 192'(bus.RSP_ERR), 192'(0));
        if (!wr) check({tag, "_rdata"}, bus.RSP_RDATA, exp_rd(int'(body)));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        logic [191:0] wd;
        int           n;
        RESET         = 1'b1;
        wait_r        = 1'b0;
        bus.CMD_VALID = 1'b0;
        bus.CMD_WRITE = 1'b0;
        bus.CMD_BODY  = 4'd0;
        bus.CMD_WDATA = '0;
        bus.RSP_READY = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;

        check("rst_cmd_ready", 192'(bus.CMD_READY), 192'(1));
        check("rst_rsp_valid", 192'(bus.RSP_VALID), 192'(0));
        check("rst_rsp_err", 192'(bus.RSP_ERR), 192'(0));
        check("rst_rdata", bus.RSP_RDATA, 192'(0));
        check("rst_strobes", 192'({bus.AVM_READ, bus.AVM_WRITE}), 192'(0));
        check("rst_addr", 192'(bus.AVM_ADDR), 192'(0));
        check("rst_wdata", 192'(bus.AVM_WRITEDATA), 192'(0));

        // Read body 2: addresses 25..75, data 0x1900..0x4B00
        run_xfer(1'b0, 4'd2, '0, 0, 0, 7, "rd_b2");
        check("rd_b2_word0", 192'(bus.RSP_RDATA[31:0]), 192'(32'h1900));
        check("rd_b2_word5", 192'(bus.RSP_RDATA[191:160]), 192'(32'h4B00));
        accept_rsp("rd_b2");

        // Write body 10 with words 1..6
        wd = '0;
        for (int k = 0; k < 6; k++) wd[k*32 +: 32] = 32'(k + 1);
        run_xfer(1'b1, 4'd10, wd, 0, 0, 7, "wr_b10");
        // After a write the read record is untouched
        check("wr_b10_rdata_kept", bus.RSP_RDATA, exp_rd(2));
        accept_rsp("wr_b10");

        // Read body 1 with 3 stall cycles on word 0 and 1 on word 4
        run_xfer(1'b0, 4'd1, '0, 3, 1, 11, "rd_b1_wait");

        // Hold off the response while a new command waits
        bus.CMD_VALID = 1'b1;
        bus.CMD_WRITE = 1'b1;
        bus.CMD_BODY  = 4'd3;
        bus.CMD_WDATA = {6{32'hA5A5_0000}};
        for (int i = 0; i < 5; i++) begin
            #1;
            check("hold_rsp_valid", 192'(bus.RSP_VALID), 192'(1));
            check("hold_rdata", bus.RSP_RDATA, exp_rd(1));
            check("hold_cmd_ready", 192'(bus.CMD_READY), 192'(0));
            check("hold_no_bus", 192'({bus.AVM_READ, bus.AVM_WRITE}), 192'(0));
            @(negedge CLK);
        end
        bus.RSP_READY = 1'b1;
        @(negedge CLK);
        bus.RSP_READY = 1'b0;
        check("hold_idle_ready", 192'(bus.CMD_READY), 192'(1));
        check("hold_idle_no_bus", 192'(bus.AVM_WRITE), 192'(0));
        @(negedge CLK);
        bus.CMD_VALID = 1'b0;
        check("held_cmd_write", 192'(bus.AVM_WRITE), 192'(1));
        check("held_cmd_addr", 192'(bus.AVM_ADDR), 192'(26));
        n = 0;
        while (!bus.RSP_VALID && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check("held_cmd_done", 192'(bus.RSP_VALID), 192'(1));
        accept_rsp("held_cmd");

        // Reset while word 3 of a write is on the bus
        bus.CMD_VALID = 1'b1;
        bus.CMD_WRITE = 1'b1;
        bus.CMD_BODY  = 4'd5;
        bus.CMD_WDATA = wd;
        @(posedge CLK);
        @(negedge CLK);
        bus.CMD_VALID = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_mid_word3_addr", 192'(bus.AVM_ADDR), 192'(58));
        check("rst_mid_word3_wdata", 192'(bus.AVM_WRITEDATA), 192'(4));
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        check("rst_mid_write", 192'(bus.AVM_WRITE), 192'(0));
        check("rst_mid_cmd_ready", 192'(bus.CMD_READY), 192'(1));
        check("rst_mid_rsp_valid", 192'(bus.RSP_VALID), 192'(0));
        check("rst_mid_rdata", bus.RSP_RDATA, 192'(0));
        run_xfer(1'b0, 4'd4, '0, 0, 0, 7, "rd_after_rst");
        accept_rsp("rd_after_rst");

`ifdef BODY_RANGE_CHECK_EN
        for (int j = 0; j < 2; j++) begin
            bus.CMD_VALID = 1'b1;
            bus.CMD_WRITE = 1'b0;
            bus.CMD_BODY  = (j == 0) ? 4'd0 : 4'd11;
            @(posedge CLK);
            @(negedge CLK);
            bus.CMD_VALID = 1'b0;
            check("range_rsp_valid", 192'(bus.RSP_VALID), 192'(1));
            check("range_rsp_err", 192'(bus.RSP_ERR), 192'(1));
            check("range_no_strobe", 192'({bus.AVM_READ, bus.AVM_WRITE}), 192'(0));
            check("range_rdata_kept", bus.RSP_RDATA, exp_rd(4));
            accept_rsp("range");
            check("range_err_clear", 192'(bus.RSP_ERR), 192'(0));
        end
`else
        // No range check: body 11 aliases into the next field's bank
        run_xfer(1'b0, 4'd11, '0, 0, 0, 7, "rd_b11");
        check("rd_b11_word0", 192'(bus.RSP_RDATA[31:0]), 192'(32'h2200));
        accept_rsp("rd_b11");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
